// File: rtl/modulation_pkg.sv
// ---------------------------------------------------------------------------
// modulation_pkg
// Shared constants and helpers for the modulation chain.
//   BPS_QPSK / BPS_QAM16 : supported bits-per-symbol values
//   LVL_*                : Gray constellation levels in units of AMP
//   gray_level()         : per-axis Gray code -> signed level
// ---------------------------------------------------------------------------
package modulation_pkg;

    localparam int BPS_QPSK  = 2;
    localparam int BPS_QAM16 = 4;

    localparam int LVL_M3 = -3;
    localparam int LVL_M1 = -1;
    localparam int LVL_P1 = 1;
    localparam int LVL_P3 = 3;

    // bits holds the per-axis code right-aligned. QPSK uses bits[0] only.
    // 16-QAM Gray order along the axis: 00, 01, 11, 10 -> -3, -1, +1, +3.
    function automatic int gray_level(input logic [1:0] bits, input int bps);
        int lvl;
        lvl = LVL_M1;
        if (bps == BPS_QPSK) begin
            lvl = bits[0] ? LVL_P1 : LVL_M1;
        end else begin
            case (bits)
                2'b00:   lvl = LVL_M3;
                2'b01:   lvl = LVL_M1;
                2'b11:   lvl = LVL_P1;
                default: lvl = LVL_P3;
            endcase
        end
        return lvl;
    endfunction

endpackage

// File: rtl/gray_axis_map.sv
// ---------------------------------------------------------------------------
// gray_axis_map
// Combinational Gray mapping of one constellation axis.
//   bits_i  [BPS/2-1:0]  axis code (MSB first as received)
//   value_o [W-1:0]      signed level * AMP, two's complement
// ---------------------------------------------------------------------------
module gray_axis_map
    import modulation_pkg::*;
#(
    parameter int BPS = 2,
    parameter int W   = 16,
    parameter int AMP = 8192
) (
    input  logic [BPS/2-1:0]     bits_i,
    output logic signed [W-1:0]  value_o
);

    logic [1:0] code;

    // Right-align the axis code into the 2-bit form the helper expects.
    generate
        if (BPS == BPS_QPSK) begin : g_qpsk
            assign code = {1'b0, bits_i};
        end else begin : g_qam16
            assign code = bits_i;
        end
    endgenerate

    // Product of a small constant level and a parameter; folds to a 4-entry mux.
    always_comb begin
        value_o = W'(gray_level(code, BPS) * AMP);
    end

endmodule

// File: rtl/qam_bit_mapper.sv
// ---------------------------------------------------------------------------
// qam_bit_mapper
// Packs BPS serial bits MSB-first and Gray-maps each group to an I/Q point.
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   s_tvalid  input bit valid
//   s_tready  input bit accepted when s_tvalid & s_tready
//   s_tdata   input bit
//   m_tvalid  symbol valid
//   m_tready  downstream ready
//   m_tdata   {I[W-1:0], Q[W-1:0]}, two's complement
//   m_tlast   last symbol of each FRAME_SYMS-symbol frame
// ---------------------------------------------------------------------------
module qam_bit_mapper
    import modulation_pkg::*;
#(
    parameter int BPS        = 2,
    parameter int W          = 16,
    parameter int AMP        = 8192,
    parameter int FRAME_SYMS = 64
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           s_tvalid,
    output logic           s_tready,
    input  logic           s_tdata,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic [2*W-1:0] m_tdata,
    output logic           m_tlast
);

    localparam int HALF = BPS / 2;
    localparam int CW   = (BPS > 2) ? $clog2(BPS) : 1;
    localparam int FCW  = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(BPS - 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAME_SYMS - 1);

    generate
        if (!(BPS == BPS_QPSK || BPS == BPS_QAM16)) begin : g_bad_bps
            $error("qam_bit_mapper: BPS must be 2 or 4");
        end
        if (3 * AMP > 2 ** (W - 1) - 1) begin : g_bad_amp
            $error("qam_bit_mapper: 3*AMP does not fit in signed W bits");
        end
        if (FRAME_SYMS < 1) begin : g_bad_frame
            $error("qam_bit_mapper: FRAME_SYMS must be at least 1");
        end
    endgenerate

    // Only the BPS-1 bits of a partial group need storage; the final bit is
    // taken straight from s_tdata when the group completes.
    logic [BPS-2:0]  sreg_q,     sreg_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [FCW-1:0]  fcnt_q,     fcnt_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic [2*W-1:0]  m_tdata_q,  m_tdata_d;
    logic            m_tlast_q,  m_tlast_d;

    logic            last_bit;
    logic            accept;
    logic            load;
    logic            out_hs;
    logic [BPS-1:0]  group_bits;
    logic [2*W-1:0]  mapped;
    logic signed [W-1:0] axis_val [2];

    assign last_bit = (cnt_q == CNT_LAST);
    // Ready depends only on state and m_tready, never on s_tvalid.
    assign s_tready = ~last_bit | ~m_tvalid_q | m_tready;
    assign accept   = s_tvalid & s_tready;
    assign load     = accept & last_bit;
    assign out_hs   = m_tvalid_q & m_tready;

    assign group_bits = {sreg_q, s_tdata};

    // Axis 0 is I (upper half of the group), axis 1 is Q (lower half).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            gray_axis_map #(
                .BPS (BPS),
                .W   (W),
                .AMP (AMP)
            ) u_map (
                .bits_i  (group_bits[BPS-1-gi*HALF -: HALF]),
                .value_o (axis_val[gi])
            );
        end
    endgenerate

    assign mapped = {axis_val[0], axis_val[1]};

    always_comb begin
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;

        if (accept) begin
            sreg_d = group_bits[BPS-2:0];
            cnt_d  = last_bit ? '0 : cnt_q + CW'(1);
        end

        if (out_hs) begin
            fcnt_d     = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCW'(1);
            m_tvalid_d = 1'b0;
        end

        // fcnt_d already accounts for a symbol draining this same cycle, so
        // it is the frame position of the symbol being loaded.
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = mapped;
            m_tlast_d  = (fcnt_d == FCNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg_q     <= '0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_qam_bit_mapper.sv
module tb_qam_bit_mapper;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // p_* : QPSK instance with 4-symbol frames
    logic        p_s_tvalid = 1'b0, p_s_tdata = 1'b0, p_m_tready = 1'b0;
    logic        p_s_tready, p_m_tvalid, p_m_tlast;
    logic [31:0] p_m_tdata;
    // x_* : 16-QAM instance with default 64-symbol frames
    logic        x_s_tvalid = 1'b0, x_s_tdata = 1'b0, x_m_tready = 1'b0;
    logic        x_s_tready, x_m_tvalid, x_m_tlast;
    logic [31:0] x_m_tdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] p_mon[$];
    logic [32:0] x_mon[$];

    qam_bit_mapper #(.BPS(2), .W(16), .AMP(8192), .FRAME_SYMS(4)) dut_qpsk (
        .clk(clk), .resetn(resetn),
        .s_tvalid(p_s_tvalid), .s_tready(p_s_tready), .s_tdata(p_s_tdata),
        .m_tvalid(p_m_tvalid), .m_tready(p_m_tready), .m_tdata(p_m_tdata),
        .m_tlast(p_m_tlast)
    );

    qam_bit_mapper #(.BPS(4), .W(16), .AMP(8192), .FRAME_SYMS(64)) dut_qam (
        .clk(clk), .resetn(resetn),
        .s_tvalid(x_s_tvalid), .s_tready(x_s_tready), .s_tdata(x_s_tdata),
        .m_tvalid(x_m_tvalid), .m_tready(x_m_tready), .m_tdata(x_m_tdata),
        .m_tlast(x_m_tlast)
    );

    // Beats are recorded mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (resetn && p_m_tvalid && p_m_tready) begin
            p_mon.push_back({p_m_tlast, p_m_tdata});
            $display("beat qpsk  tdata=%h tlast=%0b", p_m_tdata, p_m_tlast);
        end
        if (resetn && x_m_tvalid && x_m_tready) begin
            x_mon.push_back({x_m_tlast, x_m_tdata});
            $display("beat qam16 tdata=%h tlast=%0b", x_m_tdata, x_m_tlast);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Hand-computed Gray table, AMP = 0x2000: 00:-3 01:-1 11:+1 10:+3
    function automatic logic [15:0] lvl16(input logic [1:0] b);
        case (b)
            2'b00:   return 16'hA000;
            2'b01:   return 16'hE000;
            2'b11:   return 16'h2000;
            default: return 16'h6000;
        endcase
    endfunction

    function automatic logic [31:0] exp_qam(input logic [3:0] c);
        return {lvl16(c[3:2]), lvl16(c[1:0])};
    endfunction

    function automatic logic [31:0] exp_qpsk(input logic [1:0] c);
        return {(c[1] ? 16'h2000 : 16'hE000), (c[0] ? 16'h2000 : 16'hE000)};
    endfunction

    task automatic do_reset();
        p_s_tvalid = 1'b0; x_s_tvalid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Sends n bits MSB-first from bits; sel 0 = QPSK instance, 1 = 16-QAM.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            int waited;
            waited = 0;
            if (sel == 0) begin p_s_tvalid = 1'b1; p_s_tdata = bits[i]; end
            else          begin x_s_tvalid = 1'b1; x_s_tdata = bits[i]; end
            @(negedge clk);
            while (!((sel == 0) ? p_s_tready : x_s_tready) && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: sel=%0d s_tready stuck at 0, required 1 within 200 cycles", sel);
            end
            @(posedge clk); #1;
        end
        p_s_tvalid = 1'b0;
        x_s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_cmp++; if (p_m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_p_tvalid: got %b required 0", p_m_tvalid); end
        n_cmp++; if (p_m_tdata !== 32'h0) begin n_err++; $display("FAIL rst_p_tdata: got %h required 00000000", p_m_tdata); end
        n_cmp++; if (p_m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_p_tlast: got %b required 0", p_m_tlast); end
        n_cmp++; if (p_s_tready !== 1'b1) begin n_err++; $display("FAIL rst_p_tready: got %b required 1", p_s_tready); end
        n_cmp++; if (x_m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_x_tvalid: got %b required 0", x_m_tvalid); end
        n_cmp++; if (x_m_tdata !== 32'h0) begin n_err++; $display("FAIL rst_x_tdata: got %h required 00000000", x_m_tdata); end
        n_cmp++; if (x_s_tready !== 1'b1) begin n_err++; $display("FAIL rst_x_tready: got %b required 1", x_s_tready); end
        do_reset();
        n_cmp++; if (x_s_tready !== 1'b1) begin n_err++; $display("FAIL rst_release_tready: got %b required 1", x_s_tready); end
    endtask

    task automatic test_qpsk_basic();
        p_m_tready = 1'b1;
        p_s_tvalid = 1'b1; p_s_tdata = 1'b1;
        @(posedge clk); #1;
        p_s_tdata = 1'b0;
        n_cmp++; if (p_m_tvalid !== 1'b0) begin n_err++; $display("FAIL qpsk_partial: tvalid got %b required 0", p_m_tvalid); end
        @(posedge clk); #1;
        p_s_tvalid = 1'b0;
        n_cmp++; if (p_m_tvalid !== 1'b1) begin n_err++; $display("FAIL qpsk_latency: tvalid got %b required 1", p_m_tvalid); end
        n_cmp++; if (p_m_tdata !== 32'h2000_E000) begin n_err++; $display("FAIL qpsk_data: got %h required 2000e000", p_m_tdata); end
        @(posedge clk); #1;
        n_cmp++; if (p_m_tvalid !== 1'b0) begin n_err++; $display("FAIL qpsk_drain: tvalid got %b required 0", p_m_tvalid); end
    endtask

    task automatic test_qam_basic();
        x_m_tready = 1'b1;
        send_bits(1, 16'h9, 4);
        n_cmp++; if (x_m_tvalid !== 1'b1) begin n_err++; $display("FAIL qam_latency: tvalid got %b required 1", x_m_tvalid); end
        n_cmp++; if (x_m_tdata !== 32'h6000_E000) begin n_err++; $display("FAIL qam_data: got %h required 6000e000", x_m_tdata); end
        @(posedge clk); #1;
        n_cmp++; if (x_m_tvalid !== 1'b0) begin n_err++; $display("FAIL qam_drain: tvalid got %b required 0", x_m_tvalid); end
    endtask

    task automatic test_gray_sweep();
        x_mon.delete();
        x_m_tready = 1'b1;
        for (int c = 0; c < 16; c++) send_bits(1, 16'(c), 4);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (x_mon.size() !== 16) begin n_err++; $display("FAIL sweep_count: got %0d beats required 16", x_mon.size()); end
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (x_mon[c] !== {1'b0, exp_qam(4'(c))}) begin
                n_err++; $display("FAIL sweep_code_%0d: got %h required %h", c, x_mon[c], {1'b0, exp_qam(4'(c))});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] code2;
        code2 = 4'b0011;
        x_mon.delete();
        x_m_tready = 1'b0;
        send_bits(1, 16'hA, 4);
        for (int i = 3; i >= 1; i--) begin
            x_s_tvalid = 1'b1; x_s_tdata = code2[i];
            #1;
            n_cmp++; if (x_s_tready !== 1'b1) begin n_err++; $display("FAIL bp_accept_%0d: s_tready got %b required 1", i, x_s_tready); end
            @(posedge clk); #1;
        end
        x_s_tdata = code2[0];
        #1;
        n_cmp++; if (x_s_tready !== 1'b0) begin n_err++; $display("FAIL bp_block: s_tready got %b required 0", x_s_tready); end
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++; if (x_m_tdata !== 32'h6000_6000 || x_m_tvalid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold: tvalid=%b tdata=%h required 1 60006000", x_m_tvalid, x_m_tdata);
            end
            n_cmp++; if (x_s_tready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready: got %b required 0", x_s_tready); end
        end
        x_m_tready = 1'b1;
        #1;
        n_cmp++; if (x_s_tready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b required 1", x_s_tready); end
        @(posedge clk); #1;
        x_s_tvalid = 1'b0;
        n_cmp++; if (x_m_tvalid !== 1'b1 || x_m_tdata !== 32'hA000_2000) begin
            n_err++; $display("FAIL bp_no_bubble: tvalid=%b tdata=%h required 1 a0002000", x_m_tvalid, x_m_tdata);
        end
        @(posedge clk); #1;
        n_cmp++; if (x_m_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_empty: tvalid got %b required 0", x_m_tvalid); end
        n_cmp++; if (x_mon.size() !== 2) begin n_err++; $display("FAIL bp_count: got %0d beats required 2", x_mon.size()); end
        n_cmp++; if (x_mon[0] !== 33'h0_6000_6000) begin n_err++; $display("FAIL bp_beat0: got %h required 060006000", x_mon[0]); end
        n_cmp++; if (x_mon[1] !== 33'h0_A000_2000) begin n_err++; $display("FAIL bp_beat1: got %h required 0a0002000", x_mon[1]); end
    endtask

    task automatic test_framing();
        do_reset();
        p_mon.delete();
        p_m_tready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            send_bits(0, 16'(s % 4), 2);
            if (s == 3) begin
                p_m_tready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    n_cmp++; if (p_m_tvalid !== 1'b1 || p_m_tlast !== 1'b1) begin
                        n_err++; $display("FAIL frame_stall_tlast: tvalid=%b tlast=%b required 1 1", p_m_tvalid, p_m_tlast);
                    end
                    n_cmp++; if (p_m_tdata !== 32'h2000_2000) begin
                        n_err++; $display("FAIL frame_stall_data: got %h required 20002000", p_m_tdata);
                    end
                end
                p_m_tready = 1'b1;
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (p_mon.size() !== 10) begin n_err++; $display("FAIL frame_count: got %0d beats required 10", p_mon.size()); end
        for (int s = 0; s < 10; s++) begin
            logic [32:0] expv;
            expv = {(s == 3 || s == 7), exp_qpsk(2'(s % 4))};
            n_cmp++; if (p_mon[s] !== expv) begin n_err++; $display("FAIL frame_sym_%0d: got %h required %h", s, p_mon[s], expv); end
        end
    endtask

    task automatic test_pattern_feed();
        logic [64:0] pat;
        pat = 65'h1_B4F3_0C5A_9E27_D168;
        do_reset();
        x_mon.delete();
        x_m_tready = 1'b1;
        for (int i = 64; i >= 0; i--) send_bits(1, {15'b0, pat[i]}, 1);
        repeat (5) begin @(posedge clk); #1; end
        n_cmp++; if (x_mon.size() !== 16) begin n_err++; $display("FAIL feed_count: got %0d beats required 16", x_mon.size()); end
        n_cmp++; if (x_m_tvalid !== 1'b0) begin n_err++; $display("FAIL feed_held_bit: tvalid got %b required 0", x_m_tvalid); end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] nib;
            nib = pat[64 - 4*k -: 4];
            n_cmp++; if (x_mon[k] !== {1'b0, exp_qam(nib)}) begin
                n_err++; $display("FAIL feed_sym_%0d: got %h required %h", k, x_mon[k], {1'b0, exp_qam(nib)});
            end
        end
        // Completing the group must use the held 65th bit as the MSB.
        send_bits(1, 16'b101, 3);
        n_cmp++; if (x_m_tvalid !== 1'b1 || x_m_tdata !== exp_qam({pat[0], 3'b101})) begin
            n_err++; $display("FAIL feed_complete: tvalid=%b tdata=%h required 1 %h", x_m_tvalid, x_m_tdata, exp_qam({pat[0], 3'b101}));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        p_m_tready = 1'b1;
        send_bits(0, 16'h1, 2);
        send_bits(0, 16'h2, 2);
        x_m_tready = 1'b0;
        send_bits(1, 16'h5, 4);
        send_bits(1, 16'h7, 3);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (x_m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_async: tvalid got %b required 0", x_m_tvalid); end
        @(posedge clk); #1;
        resetn = 1'b1;
        x_mon.delete();
        p_mon.delete();
        x_m_tready = 1'b1;
        send_bits(1, 16'hC, 4);
        for (int s = 0; s < 4; s++) send_bits(0, 16'(s), 2);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (x_mon.size() !== 1) begin n_err++; $display("FAIL rst_mid_count: got %0d beats required 1", x_mon.size()); end
        n_cmp++; if (x_mon[0] !== 33'h0_2000_A000) begin n_err++; $display("FAIL rst_mid_sym: got %h required 02000a000", x_mon[0]); end
        n_cmp++; if (p_mon.size() !== 4) begin n_err++; $display("FAIL rst_mid_pcount: got %0d beats required 4", p_mon.size()); end
        for (int s = 0; s < 4; s++) begin
            n_cmp++; if (p_mon[s] !== {(s == 3), exp_qpsk(2'(s))}) begin
                n_err++; $display("FAIL rst_mid_frame_%0d: got %h required %h", s, p_mon[s], {(s == 3), exp_qpsk(2'(s))});
            end
        end
    endtask

    initial begin
        test_reset();
        test_qpsk_basic();
        test_qam_basic();
        test_gray_sweep();
        test_back_to_back();
        test_framing();
        test_pattern_feed();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
